// File: rtl/mult_share_ctrl.sv
// ============================================================================
// mult_share_ctrl : round-robin scheduler feeding one shared signed multiplier
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mult_share_ctrl #(
  parameter int NB   = 8,
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*NB-1:0]     req_a,
  input  logic [NREQ*NB-1:0]     req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [2*NB-1:0]        resp_product,
  output logic                   busy,
  output logic                   mul_start,
  output logic [NB-1:0]          mul_a,
  output logic [NB-1:0]          mul_b,
  input  logic [2*NB-1:0]        mul_product
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(NB - 1);

  localparam logic [2:0] C_ST_IDLE = 3'd0;
  localparam logic [2:0] C_ST_LOAD = 3'd1;
  localparam logic [2:0] C_ST_RUN  = 3'd2;
  localparam logic [2:0] C_ST_CAPT = 3'd3;
  localparam logic [2:0] C_ST_RESP = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             run_q, run_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [2*NB-1:0]  resp_product_q, resp_product_d;
  logic [NB-1:0]    mul_a_q, mul_a_d;
  logic [NB-1:0]    mul_b_q, mul_b_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   scan_idx;
  logic             accept;

  // Search upward from the rr pointer with wrap; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_q) + k) % NREQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // run_q holds off arbitration until the first edge after reset release.
  assign accept = (state_q == C_ST_IDLE) && run_q && grant_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= C_ST_IDLE;
      run_q          <= 1'b0;
      rr_q           <= '0;
      cnt_q          <= '0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      rr_q           <= rr_d;
      cnt_q          <= cnt_d;
      resp_id_q      <= resp_id_d;
      resp_product_q <= resp_product_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE: if (accept) state_d = C_ST_LOAD;
      C_ST_LOAD: state_d = C_ST_RUN;
      C_ST_RUN:  if (cnt_q == C_CNT_LAST) state_d = C_ST_CAPT;
      C_ST_CAPT: state_d = C_ST_RESP;
      C_ST_RESP: if (resp_ready) state_d = C_ST_IDLE;
      default:   state_d = C_ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    mul_start  = (state_q == C_ST_LOAD);
    busy       = (state_q != C_ST_IDLE);
    resp_valid = (state_q == C_ST_RESP);
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    run_d          = 1'b1;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    resp_id_d      = resp_id_q;
    resp_product_d = resp_product_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    if (accept) begin
      mul_a_d   = req_a[int'(grant_id)*NB +: NB];
      mul_b_d   = req_b[int'(grant_id)*NB +: NB];
      resp_id_d = grant_id;
      rr_d      = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
    if (state_q == C_ST_LOAD) cnt_d = '0;
    if (state_q == C_ST_RUN)  cnt_d = cnt_q + 1'b1;
    if (state_q == C_ST_CAPT) resp_product_d = mul_product;
  end

  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
// ============================================================================
// tb_mult_share_ctrl : randomized + directed bench against a cycle-count model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_mult_share_ctrl;

  localparam int NB   = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int RESP_AGE = NB + 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*NB-1:0]  req_a = '0;
  logic [NREQ*NB-1:0]  req_b = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [IDW-1:0]      resp_id;
  logic [2*NB-1:0]     resp_product;
  logic                busy;
  logic                mul_start;
  logic [NB-1:0]       mul_a;
  logic [NB-1:0]       mul_b;
  logic [2*NB-1:0]     mul_product = '0;

  always #5 clk = ~clk;

  mult_share_ctrl #(.NB(NB), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product),
    .busy(busy), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product)
  );

  // Sequential multiplier: NB iterations after start, garbage until done.
  int mcnt = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      mcnt        <= NB;
      mul_product <= 16'($urandom);
    end else if (mcnt > 1) begin
      mcnt        <= mcnt - 1;
      mul_product <= 16'($urandom);
    end else if (mcnt == 1) begin
      mcnt        <= 0;
      mul_product <= {{NB{mul_a[NB-1]}}, mul_a} * {{NB{mul_b[NB-1]}}, mul_b};
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference: -1 = idle, otherwise cycles elapsed since the accept edge.
  int             age = -1;
  int             rr  = 0;
  logic [IDW-1:0] exp_id = '0;
  logic [NB-1:0]  exp_a = '0, exp_b = '0;
  logic [2*NB-1:0] exp_prod = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREQ*NB-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {NB'(x3), NB'(x2), NB'(x1), NB'(x0)};
  endfunction

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*NB-1:0] a,
                      input logic [NREQ*NB-1:0] b, input logic rdy);
    int w;
    logic [NREQ-1:0] exp_rdy;
    logic [2*NB-1:0] ea, eb;
    @(negedge clk);
    req_valid  = v;
    req_a      = a;
    req_b      = b;
    resp_ready = rdy;
    #1;
    w = -1;
    if (age < 0)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && v[(rr + k) % NREQ]) w = (rr + k) % NREQ;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready",  32'(req_ready),  32'(exp_rdy));
    chk("busy",       32'(busy),       32'(age >= 0));
    chk("mul_start",  32'(mul_start),  32'(age == 0));
    chk("resp_valid", 32'(resp_valid), 32'(age == RESP_AGE));
    if (age >= 0 && age < RESP_AGE) begin
      chk("mul_a", 32'(mul_a), 32'(exp_a));
      chk("mul_b", 32'(mul_b), 32'(exp_b));
    end
    if (age == RESP_AGE) begin
      chk("resp_id",      32'(resp_id),      32'(exp_id));
      chk("resp_product", 32'(resp_product), 32'(exp_prod));
    end
    if (age < 0) begin
      if (w >= 0) begin
        exp_id   = IDW'(w);
        exp_a    = a[w*NB +: NB];
        exp_b    = b[w*NB +: NB];
        ea       = {{NB{exp_a[NB-1]}}, exp_a};
        eb       = {{NB{exp_b[NB-1]}}, exp_b};
        exp_prod = ea * eb;
        rr       = (w + 1) % NREQ;
        age      = 0;
      end
    end else if (age < RESP_AGE) begin
      age++;
    end else if (rdy) begin
      age = -1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},    32'(req_ready),    0);
    chk({tag, "_resp_valid"},   32'(resp_valid),   0);
    chk({tag, "_resp_id"},      32'(resp_id),      0);
    chk({tag, "_resp_product"}, 32'(resp_product), 0);
    chk({tag, "_mul_start"},    32'(mul_start),    0);
    chk({tag, "_mul_a"},        32'(mul_a),        0);
    chk({tag, "_mul_b"},        32'(mul_b),        0);
    chk({tag, "_busy"},         32'(busy),         0);
  endtask

  int held;
  int guard;

  initial begin
    req_valid = 4'hF;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Requester 0: 3 * -5
    step(4'b0001, pack4(3, 0, 0, 0), pack4(-5, 0, 0, 0), 1'b1);
    for (int i = 0; i < 13; i++) step(4'b0000, '0, '0, 1'b1);

    // Extremes on different requesters
    step(4'b0010, pack4(0, -128, 0, 0), pack4(0, -128, 0, 0), 1'b1);
    for (int i = 0; i < 12; i++) step(4'b0000, '0, '0, 1'b1);
    step(4'b0100, pack4(0, 0, -128, 0), pack4(0, 0, 127, 0), 1'b1);
    for (int i = 0; i < 12; i++) step(4'b0000, '0, '0, 1'b1);
    step(4'b1000, pack4(0, 0, 0, 0), pack4(0, 0, 0, -1), 1'b1);
    for (int i = 0; i < 12; i++) step(4'b0000, '0, '0, 1'b1);
    step(4'b0001, pack4(-1, 0, 0, 0), pack4(-1, 0, 0, 0), 1'b1);
    for (int i = 0; i < 12; i++) step(4'b0000, '0, '0, 1'b1);

    // All requesters pending: round-robin order
    for (int i = 0; i < 62; i++) step(4'hF, {$urandom}, {$urandom}, 1'b1);

    // Back-pressure in RESP with requests pending
    held = 0;
    for (int i = 0; i < 40; i++) begin
      logic r;
      r = !(age == RESP_AGE && held < 5);
      if (age == RESP_AGE) held++;
      step(4'hF, {$urandom}, {$urandom}, r);
    end
    for (int i = 0; i < 16; i++) step(4'b0000, '0, '0, 1'b1);

    // Reset mid-RUN with counter at 3
    step(4'b0001, pack4(5, 0, 0, 0), pack4(9, 0, 0, 0), 1'b1);
    guard = 0;
    while (age != 4 && guard < 20) begin
      step(4'b0000, '0, '0, 1'b1);
      guard++;
    end
    chk("reach_run_cnt3", 32'(age), 32'd4);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrun");
    age = -1;
    rr  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, pack4(7, 0, 0, 0), pack4(6, 0, 0, 0), 1'b1);
    for (int i = 0; i < 13; i++) step(4'b0000, '0, '0, 1'b1);

    // Move pointer to 2, then 4'b0011 pending
    step(4'b0010, pack4(0, 11, 0, 0), pack4(0, -3, 0, 0), 1'b1);
    for (int i = 0; i < 40; i++) step(4'b0011, {$urandom}, {$urandom}, 1'b1);

    // Random traffic
    for (int i = 0; i < 500; i++)
      step(4'($urandom), {$urandom}, {$urandom}, ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 16; i++) step(4'b0000, '0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
